// File: rtl/target_pkg.sv
// Shared types and defaults for the target table: FSM states, default sizing,
// and the coordinate record stored in each entry.
package target_pkg;

  localparam int DEF_NUM_TARGETS = 16;
  localparam int DEF_COORD_W     = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  typedef struct packed {
    logic [DEF_COORD_W-1:0] x;
    logic [DEF_COORD_W-1:0] y;
    logic [DEF_COORD_W-1:0] z;
    logic [DEF_COORD_W-1:0] t;
  } coord_t;

endpackage

// File: rtl/target_table_if.sv
// Request/response bundle for the target table; master drives requests,
// slave (the table) returns read data and occupancy status.
interface target_table_if
  import target_pkg::*;
#(
  parameter int NUM_TARGETS = DEF_NUM_TARGETS,
  parameter int COORD_W     = DEF_COORD_W,
  parameter int IDX_W       = $clog2(NUM_TARGETS)
);

  logic                   wr_en;
  logic [IDX_W-1:0]       wr_idx;
  logic [COORD_W-1:0]     wr_x;
  logic [COORD_W-1:0]     wr_y;
  logic [COORD_W-1:0]     wr_z;
  logic [COORD_W-1:0]     wr_t;

  logic                   clr_en;
  logic [IDX_W-1:0]       clr_idx;
  logic                   clr_all;

  logic                   rd_en;
  logic [IDX_W-1:0]       rd_idx;
  logic                   rd_done;
  logic                   rd_hit;
  logic [COORD_W-1:0]     rd_x;
  logic [COORD_W-1:0]     rd_y;
  logic [COORD_W-1:0]     rd_z;
  logic [COORD_W-1:0]     rd_t;

  logic [NUM_TARGETS-1:0] valid_mask;
  logic [IDX_W:0]         valid_count;
  logic                   full;
  logic                   busy;
  logic                   wr_drop;

  modport master (
    output wr_en, wr_idx, wr_x, wr_y, wr_z, wr_t,
    output clr_en, clr_idx, clr_all,
    output rd_en, rd_idx,
    input  rd_done, rd_hit, rd_x, rd_y, rd_z, rd_t,
    input  valid_mask, valid_count, full, busy, wr_drop
  );

  modport slave (
    input  wr_en, wr_idx, wr_x, wr_y, wr_z, wr_t,
    input  clr_en, clr_idx, clr_all,
    input  rd_en, rd_idx,
    output rd_done, rd_hit, rd_x, rd_y, rd_z, rd_t,
    output valid_mask, valid_count, full, busy, wr_drop
  );

endinterface

// File: rtl/target_entry.sv
// One table slot: valid bit plus coordinate record. Clear beats load; valid_nxt
// exposes the post-edge valid bit so the parent can keep its count in step.
module target_entry
  import target_pkg::*;
#(
  parameter type entry_t = coord_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   clear,
  input  entry_t din,
  output logic   valid,
  output logic   valid_nxt,
  output entry_t dout
);

  always_comb begin
    valid_nxt = valid;
    if (clear)
      valid_nxt = 1'b0;
    else if (load)
      valid_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end
  end

endmodule

// File: rtl/target_table.sv
// Indexed table of coordinate entries with single-entry write/clear/read and a
// background clear-all sweep that walks entries 0..NUM_TARGETS-1, one per cycle.
//
//   state | meaning
//   IDLE  | normal operation, clr_all sampled here
//   SWEEP | clearing entry sweep_idx this cycle, writes rejected
module target_table
  import target_pkg::*;
#(
  parameter int NUM_TARGETS = DEF_NUM_TARGETS,
  parameter int COORD_W     = DEF_COORD_W,
  parameter int IDX_W       = $clog2(NUM_TARGETS)
) (
  input logic           clk,
  input logic           rst,
  target_table_if.slave bus
);

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
    logic [COORD_W-1:0] t;
  } entry_coord_t;

  localparam logic [IDX_W:0]   NT   = NUM_TARGETS[IDX_W:0];
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_TARGETS - 1);

  state_t           state;
  logic [IDX_W-1:0] sweep_idx;
  logic             busy_q;

  logic             wr_in_range;
  logic             wr_ok;
  entry_coord_t     wr_coord;

  logic [NUM_TARGETS-1:0] load;
  logic [NUM_TARGETS-1:0] clear;
  logic [NUM_TARGETS-1:0] valid;
  logic [NUM_TARGETS-1:0] valid_nxt;
  entry_coord_t           ent_data [NUM_TARGETS];

  logic [IDX_W:0]   cnt_nxt;
  logic [IDX_W:0]   cnt_q;
  logic             full_q;
  logic             drop_q;

  entry_coord_t     rd_sel;
  logic             rd_sel_hit;
  entry_coord_t     rd_q;
  logic             rd_done_q;
  logic             rd_hit_q;

  assign wr_in_range = ({1'b0, bus.wr_idx} < NT);
  // A clear on the same slot wins over the write, which is then reported as dropped.
  assign wr_ok = bus.wr_en && wr_in_range && !busy_q &&
                 !(bus.clr_en && (bus.clr_idx == bus.wr_idx));

  assign wr_coord.x = bus.wr_x;
  assign wr_coord.y = bus.wr_y;
  assign wr_coord.z = bus.wr_z;
  assign wr_coord.t = bus.wr_t;

  genvar i;
  generate
    for (i = 0; i < NUM_TARGETS; i++) begin : g_ent
      assign load[i]  = wr_ok && (bus.wr_idx == IDX_W'(i));
      assign clear[i] = (bus.clr_en && (bus.clr_idx == IDX_W'(i))) ||
                        (busy_q && (sweep_idx == IDX_W'(i)));

      target_entry #(
        .entry_t (entry_coord_t)
      ) u_entry (
        .clk       (clk),
        .rst       (rst),
        .load      (load[i]),
        .clear     (clear[i]),
        .din       (wr_coord),
        .valid     (valid[i]),
        .valid_nxt (valid_nxt[i]),
        .dout      (ent_data[i])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sweep_idx <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clr_all) begin
            state     <= SWEEP;
            sweep_idx <= '0;
            busy_q    <= 1'b1;
          end
        end
        SWEEP: begin
          if (sweep_idx == LAST) begin
            state     <= IDLE;
            sweep_idx <= '0;
            busy_q    <= 1'b0;
          end else begin
            sweep_idx <= sweep_idx + IDX_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Count is taken from the next-state valid bits so it lands with valid_mask.
  always_comb begin
    cnt_nxt = '0;
    for (int k = 0; k < NUM_TARGETS; k++)
      cnt_nxt = cnt_nxt + (IDX_W+1)'(valid_nxt[k]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_nxt;
      full_q <= (cnt_nxt == NT);
      drop_q <= bus.wr_en && !wr_ok;
    end
  end

  // Out-of-range indices match no slot, so they naturally read back as a miss.
  always_comb begin
    rd_sel     = '0;
    rd_sel_hit = 1'b0;
    for (int k = 0; k < NUM_TARGETS; k++) begin
      if ((bus.rd_idx == IDX_W'(k)) && valid[k]) begin
        rd_sel     = ent_data[k];
        rd_sel_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_done_q <= 1'b0;
      rd_hit_q  <= 1'b0;
      rd_q      <= '0;
    end else begin
      rd_done_q <= bus.rd_en;
      if (bus.rd_en) begin
        rd_hit_q <= rd_sel_hit;
        rd_q     <= rd_sel;
      end
    end
  end

  assign bus.rd_done     = rd_done_q;
  assign bus.rd_hit      = rd_hit_q;
  assign bus.rd_x        = rd_q.x;
  assign bus.rd_y        = rd_q.y;
  assign bus.rd_z        = rd_q.z;
  assign bus.rd_t        = rd_q.t;
  assign bus.valid_mask  = valid;
  assign bus.valid_count = cnt_q;
  assign bus.full        = full_q;
  assign bus.busy        = busy_q;
  assign bus.wr_drop     = drop_q;

endmodule

// File: tb/tb_target_table.sv
// Bench for target_table: default 16x8 instance and a 10x12 instance, driven by
// directed and random requests and compared against an array-based model.
module tb_target_table;

  localparam int N_A  = 16;
  localparam int CW_A = 8;
  localparam int IW_A = 4;
  localparam int N_B  = 10;
  localparam int CW_B = 12;
  localparam int IW_B = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  target_table_if #(.NUM_TARGETS(N_A), .COORD_W(CW_A)) bus_a ();
  target_table_if #(.NUM_TARGETS(N_B), .COORD_W(CW_B)) bus_b ();

  target_table #(.NUM_TARGETS(N_A), .COORD_W(CW_A)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  target_table #(.NUM_TARGETS(N_B), .COORD_W(CW_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct {
    bit rst, wr, clr, all, rd;
    int wi, ci, ri;
    int x, y, z, t;
  } stim_t;

  typedef struct {
    int cyc;
    bit hit;
    int x, y, z, t;
  } rd_exp_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int sel      = 0;
  int nt       = N_A;
  int cw       = CW_A;

  bit mval [64];
  int mx [64], my [64], mz [64], mt [64];
  int sweep_left, sweep_pos;
  bit exp_drop, exp_rd_done;
  bit hold_hit;
  int hold_x, hold_y, hold_z, hold_t;
  rd_exp_t q_a [$];
  rd_exp_t q_b [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic stim_t nop();
    stim_t s;
    s.rst = 0; s.wr = 0; s.clr = 0; s.all = 0; s.rd = 0;
    s.wi = 0; s.ci = 0; s.ri = 0; s.x = 0; s.y = 0; s.z = 0; s.t = 0;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    rst = s.rst;
    bus_a.wr_en = 0; bus_a.clr_en = 0; bus_a.clr_all = 0; bus_a.rd_en = 0;
    bus_b.wr_en = 0; bus_b.clr_en = 0; bus_b.clr_all = 0; bus_b.rd_en = 0;
    bus_a.wr_idx = IW_A'(s.wi); bus_a.clr_idx = IW_A'(s.ci); bus_a.rd_idx = IW_A'(s.ri);
    bus_b.wr_idx = IW_B'(s.wi); bus_b.clr_idx = IW_B'(s.ci); bus_b.rd_idx = IW_B'(s.ri);
    bus_a.wr_x = CW_A'(s.x); bus_a.wr_y = CW_A'(s.y); bus_a.wr_z = CW_A'(s.z); bus_a.wr_t = CW_A'(s.t);
    bus_b.wr_x = CW_B'(s.x); bus_b.wr_y = CW_B'(s.y); bus_b.wr_z = CW_B'(s.z); bus_b.wr_t = CW_B'(s.t);
    if (sel == 0) begin
      bus_a.wr_en = s.wr; bus_a.clr_en = s.clr; bus_a.clr_all = s.all; bus_a.rd_en = s.rd;
    end else begin
      bus_b.wr_en = s.wr; bus_b.clr_en = s.clr; bus_b.clr_all = s.all; bus_b.rd_en = s.rd;
    end
  endtask

  task automatic kill(input int idx);
    mval[idx] = 0; mx[idx] = 0; my[idx] = 0; mz[idx] = 0; mt[idx] = 0;
  endtask

  // Reference behaviour for one clock edge, evaluated on the pre-edge table.
  task automatic model(input stim_t s);
    rd_exp_t e;
    bit busy_m;
    int msk;
    msk = (1 << cw) - 1;
    exp_rd_done = 0;
    if (s.rst) begin
      for (int k = 0; k < 64; k++) kill(k);
      sweep_left = 0; sweep_pos = 0; exp_drop = 0;
      hold_hit = 0; hold_x = 0; hold_y = 0; hold_z = 0; hold_t = 0;
      return;
    end
    busy_m = (sweep_left > 0);
    if (s.rd) begin
      e.cyc = cyc + 1;
      e.hit = (s.ri < nt) && mval[s.ri];
      e.x = e.hit ? mx[s.ri] : 0; e.y = e.hit ? my[s.ri] : 0;
      e.z = e.hit ? mz[s.ri] : 0; e.t = e.hit ? mt[s.ri] : 0;
      if (sel == 0) q_a.push_back(e); else q_b.push_back(e);
      exp_rd_done = 1;
      hold_hit = e.hit; hold_x = e.x; hold_y = e.y; hold_z = e.z; hold_t = e.t;
    end
    exp_drop = s.wr && ((s.wi >= nt) || busy_m || (s.clr && (s.ci == s.wi)));
    if (busy_m) kill(sweep_pos);
    if (s.clr && (s.ci < nt)) kill(s.ci);
    if (s.wr && !exp_drop) begin
      mval[s.wi] = 1;
      mx[s.wi] = s.x & msk; my[s.wi] = s.y & msk; mz[s.wi] = s.z & msk; mt[s.wi] = s.t & msk;
    end
    if (busy_m) begin
      sweep_pos++; sweep_left--;
    end else if (s.all) begin
      sweep_left = nt; sweep_pos = 0;
    end
  endtask

  task automatic compare();
    int mask_exp, cnt_exp;
    int mask_act, cnt_act, full_act, busy_act, drop_act, done_act, hit_act;
    int xa, ya, za, ta;
    mask_exp = 0; cnt_exp = 0;
    for (int k = 0; k < nt; k++)
      if (mval[k]) begin mask_exp |= (1 << k); cnt_exp++; end
    if (sel == 0) begin
      mask_act = int'(bus_a.valid_mask); cnt_act = int'(bus_a.valid_count);
      full_act = int'(bus_a.full); busy_act = int'(bus_a.busy); drop_act = int'(bus_a.wr_drop);
      done_act = int'(bus_a.rd_done); hit_act = int'(bus_a.rd_hit);
      xa = int'(bus_a.rd_x); ya = int'(bus_a.rd_y); za = int'(bus_a.rd_z); ta = int'(bus_a.rd_t);
    end else begin
      mask_act = int'(bus_b.valid_mask); cnt_act = int'(bus_b.valid_count);
      full_act = int'(bus_b.full); busy_act = int'(bus_b.busy); drop_act = int'(bus_b.wr_drop);
      done_act = int'(bus_b.rd_done); hit_act = int'(bus_b.rd_hit);
      xa = int'(bus_b.rd_x); ya = int'(bus_b.rd_y); za = int'(bus_b.rd_z); ta = int'(bus_b.rd_t);
    end
    check("valid_mask", mask_act, mask_exp);
    check("valid_count", cnt_act, cnt_exp);
    check("full", full_act, int'(cnt_exp == nt));
    check("busy", busy_act, int'(sweep_left > 0));
    check("wr_drop", drop_act, int'(exp_drop));
    check("rd_done", done_act, int'(exp_rd_done));
    if (!exp_rd_done) begin
      check("rd_hit_held", hit_act, int'(hold_hit));
      check("rd_x_held", xa, hold_x); check("rd_y_held", ya, hold_y);
      check("rd_z_held", za, hold_z); check("rd_t_held", ta, hold_t);
    end
  endtask

  task automatic step(input stim_t s);
    drive(s);
    model(s);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic pop_check(input rd_exp_t e, input int hit, input int x, input int y,
                           input int z, input int t);
    check("rd_latency", cyc, e.cyc);
    check("rd_hit", hit, int'(e.hit));
    check("rd_x", x, e.x); check("rd_y", y, e.y);
    check("rd_z", z, e.z); check("rd_t", t, e.t);
  endtask

  always @(negedge clk) begin
    if (bus_a.rd_done === 1'b1) begin
      if (q_a.size() == 0) check("rd_unexpected_a", 1, 0);
      else pop_check(q_a.pop_front(), int'(bus_a.rd_hit), int'(bus_a.rd_x),
                     int'(bus_a.rd_y), int'(bus_a.rd_z), int'(bus_a.rd_t));
    end
    if (bus_b.rd_done === 1'b1) begin
      if (q_b.size() == 0) check("rd_unexpected_b", 1, 0);
      else pop_check(q_b.pop_front(), int'(bus_b.rd_hit), int'(bus_b.rd_x),
                     int'(bus_b.rd_y), int'(bus_b.rd_z), int'(bus_b.rd_t));
    end
  end

  function automatic stim_t rand_stim(input int max_idx, input int w);
    stim_t s;
    int m;
    m = (1 << w) - 1;
    s = nop();
    s.rst = ($urandom_range(0, 249) == 0);
    s.wr  = $urandom_range(0, 1) == 1;
    s.wi  = $urandom_range(0, max_idx);
    s.clr = ($urandom_range(0, 4) == 0);
    s.ci  = ($urandom_range(0, 3) == 0) ? s.wi : $urandom_range(0, max_idx);
    s.all = ($urandom_range(0, 59) == 0);
    s.rd  = $urandom_range(0, 1) == 1;
    s.ri  = ($urandom_range(0, 3) == 0) ? s.wi : $urandom_range(0, max_idx);
    s.x = $urandom_range(0, m); s.y = $urandom_range(0, m);
    s.z = $urandom_range(0, m); s.t = $urandom_range(0, m);
    return s;
  endfunction

  function automatic stim_t wr_stim(input int idx, input int x, input int y, input int z, input int t);
    stim_t s;
    s = nop(); s.wr = 1; s.wi = idx; s.x = x; s.y = y; s.z = z; s.t = t;
    return s;
  endfunction

  function automatic stim_t rd_stim(input int idx);
    stim_t s;
    s = nop(); s.rd = 1; s.ri = idx;
    return s;
  endfunction

  initial begin
    stim_t s;
    sel = 0; nt = N_A; cw = CW_A;
    s = nop(); s.rst = 1;
    step(s); step(s);
    check("reset_rd_x", int'(bus_a.rd_x), 0);
    check("reset_rd_hit", int'(bus_a.rd_hit), 0);

    step(wr_stim(3, 'h11, 'h22, 'h33, 'h44));
    step(rd_stim(3));
    check("first_read_x", int'(bus_a.rd_x), 'h11);
    check("first_read_t", int'(bus_a.rd_t), 'h44);
    step(nop());

    for (int i = 0; i < N_A; i++)
      step(wr_stim(i, $urandom_range(0, 255), $urandom_range(0, 255),
                   $urandom_range(0, 255), $urandom_range(0, 255)));
    check("fill_full", int'(bus_a.full), 1);
    s = nop(); s.clr = 1; s.ci = 5; step(s);
    check("clr5_count", int'(bus_a.valid_count), 15);
    step(rd_stim(5));
    step(nop());

    s = wr_stim(7, 1, 2, 3, 4); s.clr = 1; s.ci = 7; step(s);
    check("collide_drop", int'(bus_a.wr_drop), 1);
    step(nop());
    s = wr_stim(1, 9, 9, 9, 9); s.clr = 1; s.ci = 6; step(s);
    step(wr_stim(5, 5, 5, 5, 5));
    step(wr_stim(6, 6, 6, 6, 6));
    step(wr_stim(7, 7, 7, 7, 7));
    s = wr_stim(8, 'h80, 'h81, 'h82, 'h83); s.rd = 1; s.ri = 8; step(s);

    s = nop(); s.all = 1; step(s);
    for (int k = 0; k < 18; k++) begin
      s = nop();
      if (k == 3) begin s.wr = 1; s.wi = 15; s.x = 'hAA; end
      if (k == 5) s.all = 1;
      if (k % 4 == 1) begin s.rd = 1; s.ri = k; end
      step(s);
    end
    check("sweep_empty", int'(bus_a.valid_mask), 0);

    for (int i = 0; i < N_A; i++) step(wr_stim(i, i, i + 1, i + 2, i + 3));
    s = nop(); s.all = 1; step(s);
    step(nop()); step(nop()); step(nop());
    s = nop(); s.rst = 1; step(s);
    check("rst_mid_sweep_busy", int'(bus_a.busy), 0);
    step(nop());

    for (int k = 0; k < 700; k++) step(rand_stim(N_A - 1, CW_A));

    sel = 1; nt = N_B; cw = CW_B;
    s = nop(); s.rst = 1;
    step(s); step(s);
    step(wr_stim(2, 'h123, 'h456, 'h789, 'hFFF));
    step(wr_stim(12, 1, 1, 1, 1));
    check("oor_write_drop", int'(bus_b.wr_drop), 1);
    step(wr_stim(9, 'hABC, 'hABC, 'hABC, 'hABC));
    step(rd_stim(9));
    check("abc_read_x", int'(bus_b.rd_x), 'hABC);
    step(rd_stim(13));
    s = nop(); s.clr = 1; s.ci = 11; step(s);
    for (int k = 0; k < 400; k++) step(rand_stim(15, CW_B));

    s = nop(); step(s); step(s);
    @(negedge clk);
    check("rd_queue_a_drained", q_a.size(), 0);
    check("rd_queue_b_drained", q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/target_table.md
TARGET_TABLE -- requirements
Module: target_table

Interface
REQ-001 Parameter NUM_TARGETS, default 16, number of target entries (2..64).
REQ-002 Parameter COORD_W, default 8, width of each of X, Y, Z, T fields.
REQ-003 Parameter IDX_W, default clog2(NUM_TARGETS), entry index width.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 wr_en  in  1  write request; wr_idx in IDX_W entry; wr_x/wr_y/wr_z/wr_t in COORD_W each, coordinates.
REQ-007 clr_en  in  1  clear single entry; clr_idx in IDX_W entry.
REQ-008 clr_all  in  1  start clear-all sweep (sampled only in IDLE).
REQ-009 rd_en  in  1  read request; rd_idx in IDX_W entry.
REQ-010 rd_done  out  1  read response strobe; rd_hit out 1, entry valid; rd_x/rd_y/rd_z/rd_t out COORD_W each.
REQ-011 valid_mask  out  NUM_TARGETS  per-entry valid bits; valid_count out IDX_W+1, population count; full out 1.
REQ-012 busy  out  1  sweep in progress; wr_drop out 1, one-cycle pulse when a write is rejected.

Function
REQ-013 Write: wr_en with wr_idx < NUM_TARGETS, not busy -> entry fields loaded and valid bit set at the next edge.
REQ-014 Single clear: clr_en with clr_idx < NUM_TARGETS -> valid bit cleared and entry fields zeroed at the next edge.
REQ-015 Same-cycle wr_en and clr_en on the same index: clear wins, wr_drop pulses.
REQ-016 Same-cycle wr_en and clr_en on different indices: both take effect.
REQ-017 Index >= NUM_TARGETS on any port: request ignored; a write additionally pulses wr_drop; a read returns rd_hit=0 with zero data.
REQ-018 Read latency is 1 cycle: rd_done and data registered; rd_done=0 and data held otherwise.
REQ-019 Read of an invalid entry: rd_done=1, rd_hit=0, data all zero.
REQ-020 Read and write to the same index in the same cycle return the pre-write contents (read-before-write).
REQ-021 FSM states IDLE, SWEEP. IDLE->SWEEP on clr_all; SWEEP clears one entry per cycle, index 0 upward; SWEEP->IDLE after entry NUM_TARGETS-1 is cleared.
REQ-022 busy=1 throughout SWEEP, exactly NUM_TARGETS cycles; all writes during SWEEP rejected with wr_drop; reads are served normally.
REQ-023 clr_all asserted during SWEEP is ignored (sweep is not restarted).
REQ-024 valid_count and full are registered and consistent with valid_mask in the same cycle; full = (valid_count == NUM_TARGETS).
REQ-025 Write to an already valid entry overwrites it; valid_count is unchanged.

Reset
REQ-026 rst has priority over all requests, including mid-sweep; next cycle state is IDLE.
REQ-027 After rst: valid_mask=0, valid_count=0, full=0, busy=0, rd_done=0, rd_hit=0, wr_drop=0, rd_x/rd_y/rd_z/rd_t=0, all entry fields zero.

Structure
REQ-028 Shared package target_pkg holds the FSM state enum (IDLE, SWEEP), default NUM_TARGETS and COORD_W, and a packed coordinate struct type {x,y,z,t}.
REQ-029 One sub-module, target_entry: a single entry holding its valid bit and coordinate struct, with load/clear inputs; instantiated NUM_TARGETS times via generate.
REQ-030 All parameters shall be overridable; no logic shall assume a power-of-2 NUM_TARGETS.

Verification
REQ-031 After rst, write idx 3 = (0x11,0x22,0x33,0x44), read idx 3 -> next cycle rd_done=1, rd_hit=1, data (0x11,0x22,0x33,0x44); valid_count=1.
REQ-032 Fill all 16 entries -> full=1, valid_count=16; clr_en idx 5 -> full=0, valid_count=15, read idx 5 -> rd_hit=0, data 0.
REQ-033 Same-cycle wr_en and clr_en on idx 7 (entry valid) -> entry invalid, wr_drop=1 for one cycle, valid_count decrements by 1.
REQ-034 clr_all with 16 valid entries -> busy=1 for exactly 16 cycles; write during sweep -> wr_drop=1, not stored; afterwards valid_mask=0.
REQ-035 Assert rst on sweep cycle 4 -> next cycle busy=0, valid_mask=0, valid_count=0.
REQ-036 NUM_TARGETS=10, COORD_W=12: write idx 12 -> wr_drop=1, valid_mask unchanged; write idx 9 = 0xABC on all fields -> read-back matches.
